counter_updown_mod: RTL

- Parametrised up/down counter, successor to the fixed 32-bit load/up/down counter.
- Adds: configurable width and modulus, count enable, four run modes (wrap, saturate, one-shot, auto-reload), done flag, registered terminal-count pulse Rc.
- Used as the general timer/event counter in the FSM lab designs; also cascadable (see optional feature).

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_step_logic.sv | 31 +++
 rtl/counter_updown_mod.sv | 111 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared run-mode codes and FSM state type for the parametrised up/down counter.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RELOAD  = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/counter_step_logic.sv
// Combinational step datapath: terminal detection and the value cnt takes on an enabled step.
module counter_step_logic
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             s,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] reload_reg,
    output logic             terminal,
    output logic [WIDTH-1:0] step_val
);

    always_comb begin
        terminal = s ? (cnt == MAX_VAL) : (cnt == '0);
        step_val = cnt;
        if (!terminal) begin
            step_val = s ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
        end else begin
            // terminal behaviour keeps the range 0..MAX_VAL closed (modulo MAX_VAL+1)
            unique case (mode)
                MODE_WRAP:    step_val = s ? '0 : MAX_VAL;
                MODE_RELOAD:  step_val = reload_reg;
                default:      step_val = cnt;
            endcase
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with wrap/sat/one-shot/reload modes.
// Define CNT_CASCADE_EN to add ci/co ports for synchronous multi-stage chaining.
//
// state   | meaning
// ST_RUN  | counting permitted
// ST_DONE | one-shot finished; en ignored, cnt holds, done=1
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s,
    input  logic             Load,
    input  logic [WIDTH-1:0] PData,
    input  logic [1:0]       mode,
`ifdef CNT_CASCADE_EN
    input  logic             ci,
    output logic             co,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             Rc,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             rc_nxt, done_nxt;
    logic             terminal;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic             step_ok;

`ifdef CNT_CASCADE_EN
    assign step_ok = en & ci;
    assign co      = step_ok & terminal & (state == ST_RUN);
`else
    assign step_ok = en;
`endif

    assign load_val = (PData > MAX_VAL) ? MAX_VAL : PData;

    counter_step_logic #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step (
        .cnt        (cnt),
        .s          (s),
        .mode       (mode),
        .reload_reg (reload_reg),
        .terminal   (terminal),
        .step_val   (step_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            cnt        <= RST_VAL;
            reload_reg <= RST_VAL;
            Rc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            reload_reg <= reload_nxt;
            Rc         <= rc_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        reload_nxt = reload_reg;
        rc_nxt     = 1'b0;
        done_nxt   = done;
        if (Load) begin
            cnt_nxt    = load_val;
            reload_nxt = load_val;
            state_nxt  = ST_RUN;
            done_nxt   = 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (step_ok) begin
                        cnt_nxt = step_val;
                        rc_nxt  = terminal;
                        if (terminal && mode == MODE_ONESHOT) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // leaving one-shot mode releases the counter without a step
                    if (mode != MODE_ONESHOT) begin
                        state_nxt = ST_RUN;
                        done_nxt  = 1'b0;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

endmodule
